// File: rtl/convert_8_bit_if.sv
// -----------------------------------------------------------------------------
// convert_8_bit_if
// Bundles the data-path signals of the float-to-fixed converter.
//
// Signals:
//   clk_en  - pipeline advance enable (driven by the producer)
//   dataa   - IEEE-754 single-precision operand (driven by the producer)
//   result  - signed two's-complement fixed-point value (driven by the converter)
//
// Modports:
//   master  - producer/consumer side (testbench or upstream logic)
//   slave   - converter side
// -----------------------------------------------------------------------------
interface convert_8_bit_if #(
    parameter int FLOAT_WIDTH = 32,
    parameter int OUT_WIDTH   = 32
);
    logic                   clk_en;
    logic [FLOAT_WIDTH-1:0] dataa;
    logic [OUT_WIDTH-1:0]   result;

    modport master (
        output clk_en,
        output dataa,
        input  result
    );

    modport slave (
        input  clk_en,
        input  dataa,
        output result
    );
endinterface

// File: rtl/convert_8_bit.sv
// -----------------------------------------------------------------------------
// convert_8_bit
// Three-stage pipelined converter from IEEE-754 single precision to signed
// fixed point Q(INT_WIDTH).(FRAC_WIDTH), sign-extended to OUT_WIDTH bits.
// Rounds toward zero, saturates out-of-range values (infinity included) and
// maps zero, denormals, tiny values and NaN to 0.
//
// Ports:
//   clk          - clock, all state changes on the rising edge
//   rst          - synchronous active-high reset, overrides bus.clk_en
//   bus.clk_en   - advance all pipeline stages when 1, hold when 0
//   bus.dataa    - floating-point operand
//   bus.result   - registered fixed-point result, 3 enabled edges of latency
// -----------------------------------------------------------------------------
module convert_8_bit #(
    parameter int FLOAT_WIDTH = 32,
    parameter int INT_WIDTH   = 4,
    parameter int FRAC_WIDTH  = 20,
    parameter int OUT_WIDTH   = 32
) (
    input  logic           clk,
    input  logic           rst,
    convert_8_bit_if.slave bus
);
    localparam int FIX_W = INT_WIDTH + FRAC_WIDTH;

    // The 24-bit mantissa holds the value mant * 2^(exp-150); scaling by
    // 2^FRAC_WIDTH makes the shift distance (exp - SHIFT_BASE).
    localparam logic [7:0] SHIFT_BASE = 8'(150 - FRAC_WIDTH);
    // |value| >= 2^(INT_WIDTH-1) no longer fits in the signed format.
    localparam logic [7:0] SAT_EXP    = 8'(126 + INT_WIDTH);
    // Below this exponent even the hidden 1 is shifted fully out.
    localparam logic [7:0] MIN_EXP    = 8'(150 - FRAC_WIDTH - 23);

    localparam logic [FIX_W-1:0] POS_SAT = {1'b0, {(FIX_W-1){1'b1}}};
    localparam logic [FIX_W-1:0] NEG_SAT = {1'b1, {(FIX_W-1){1'b0}}};

    // Stage 1 registers: unpacked operand and class flags
    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [23:0] s1_mant;
    logic        s1_zero;
    logic        s1_sat;

    // Stage 2 registers: truncated magnitude and class flags
    logic        s2_sign;
    logic [23:0] s2_mag;
    logic        s2_zero;
    logic        s2_sat;

    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_frac;
    logic        in_nan;
    logic        in_zero;
    logic        in_sat;

    logic [FIX_W-1:0] fix_next;

    // Operand classification. NaN is folded into the zero class so it never
    // reaches the saturation path even though its exponent is all ones.
    always_comb begin
        in_sign = bus.dataa[FLOAT_WIDTH-1];
        in_exp  = bus.dataa[30:23];
        in_frac = bus.dataa[22:0];
        in_nan  = (in_exp == 8'hFF) && (in_frac != 23'd0);
        in_zero = in_nan || (in_exp < MIN_EXP);
        in_sat  = !in_nan && (in_exp >= SAT_EXP);
    end

    // Final stage value. Only right shifts of 1..23 reach the magnitude path;
    // everything needing a left shift is already flagged for saturation.
    always_comb begin
        fix_next = '0;
        if (s2_zero) begin
            fix_next = '0;
        end else if (s2_sat) begin
            fix_next = s2_sign ? NEG_SAT : POS_SAT;
        end else if (s2_sign) begin
            fix_next = -FIX_W'(s2_mag);
        end else begin
            fix_next = FIX_W'(s2_mag);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sign    <= 1'b0;
            s1_exp     <= 8'd0;
            s1_mant    <= 24'd0;
            s1_zero    <= 1'b0;
            s1_sat     <= 1'b0;
            s2_sign    <= 1'b0;
            s2_mag     <= 24'd0;
            s2_zero    <= 1'b0;
            s2_sat     <= 1'b0;
            bus.result <= '0;
        end else if (bus.clk_en) begin
            s1_sign    <= in_sign;
            s1_exp     <= in_exp;
            s1_mant    <= {(in_exp != 8'd0), in_frac};
            s1_zero    <= in_zero;
            s1_sat     <= in_sat;
            s2_sign    <= s1_sign;
            s2_mag     <= s1_mant >> (SHIFT_BASE - s1_exp);
            s2_zero    <= s1_zero;
            s2_sat     <= s1_sat;
            bus.result <= {{(OUT_WIDTH-FIX_W){fix_next[FIX_W-1]}}, fix_next};
        end
    end
endmodule

// File: tb/tb_convert_8_bit.sv
// -----------------------------------------------------------------------------
// tb_convert_8_bit
// Self-checking bench for convert_8_bit: directed vector table, hand-written
// stall / back-to-back / reset sequences, then randomized operands compared
// against a real-arithmetic reference model with a 3-deep latency queue.
// -----------------------------------------------------------------------------
module tb_convert_8_bit;
    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    convert_8_bit_if #(.FLOAT_WIDTH(32), .OUT_WIDTH(32)) bus ();

    convert_8_bit #(
        .FLOAT_WIDTH(32),
        .INT_WIDTH  (4),
        .FRAC_WIDTH (20),
        .OUT_WIDTH  (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dataa;
        logic [31:0] expected;
        string       name;
    } vec_t;

    vec_t vectors[$];

    // Reference model: values in flight, oldest at the front
    logic [31:0] model_q[$];
    logic [31:0] model_res;

    function automatic real pow2(input int n);
        real p = 1.0;
        if (n >= 0) repeat (n) p = p * 2.0;
        else repeat (-n) p = p / 2.0;
        return p;
    endfunction

    // Real-valued reading of the float, truncated toward zero in units of 2^-20
    function automatic logic [31:0] ref_convert(input logic [31:0] f);
        int  e;
        int  frac;
        int  m;
        real v;
        e    = int'(f[30:23]);
        frac = int'(f[22:0]);
        if (e == 255 && frac != 0) return 32'h0000_0000;
        if (e == 255) return f[31] ? 32'hFF80_0000 : 32'h007F_FFFF;
        if (e == 0) return 32'h0000_0000;
        v = (1.0 + $itor(frac) / 8388608.0) * pow2(e - 127);
        if (v >= 8.0) return f[31] ? 32'hFF80_0000 : 32'h007F_FFFF;
        m = $rtoi(v * 1048576.0);
        if (f[31]) m = -m;
        return m;
    endfunction

    task automatic apply_stimulus(input logic r, input logic en, input logic [31:0] d);
        rst        = r;
        bus.clk_en = en;
        bus.dataa  = d;
        @(posedge clk);
        #1;
        if (r) begin
            model_q   = '{32'd0, 32'd0};
            model_res = 32'd0;
        end else if (en) begin
            model_q.push_back(ref_convert(d));
            model_res = model_q.pop_front();
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] expected);
        checks++;
        if (bus.result !== expected) begin
            failures++;
            $display("[TB] FAIL %s: result=%h required=%h", name, bus.result, expected);
        end
    endtask

    function automatic logic [31:0] random_operand();
        logic [31:0] d;
        d = $urandom;
        case ($urandom_range(0, 4))
            0: ;
            1: d[30:23] = 8'($urandom_range(100, 135));
            2: d[30:23] = 8'($urandom_range(126, 129));
            3: d[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            default: d[30:23] = 8'($urandom_range(105, 108));
        endcase
        return d;
    endfunction

    initial begin
        model_q   = '{32'd0, 32'd0};
        model_res = 32'd0;

        vectors.push_back('{32'h3F80_0000, 32'h0010_0000, "one"});
        vectors.push_back('{32'h3F1B_74EE, 32'h0009_B74E, "0p607"});
        vectors.push_back('{32'hBFC0_0000, 32'hFFE8_0000, "neg_1p5"});
        vectors.push_back('{32'hBF80_0000, 32'hFFF0_0000, "neg_one"});
        vectors.push_back('{32'h4120_0000, 32'h007F_FFFF, "ten_sat"});
        vectors.push_back('{32'hC2C8_0000, 32'hFF80_0000, "neg_100_sat"});
        vectors.push_back('{32'h7F80_0000, 32'h007F_FFFF, "pos_inf"});
        vectors.push_back('{32'hFF80_0000, 32'hFF80_0000, "neg_inf"});
        vectors.push_back('{32'h7FC0_0000, 32'h0000_0000, "nan"});
        vectors.push_back('{32'h8000_0000, 32'h0000_0000, "neg_zero"});
        vectors.push_back('{32'h3380_0000, 32'h0000_0000, "two_m24"});
        vectors.push_back('{32'h3580_0000, 32'h0000_0001, "two_m20"});
        vectors.push_back('{32'hB580_0000, 32'hFFFF_FFFF, "neg_two_m20"});
        vectors.push_back('{32'h3500_0000, 32'h0000_0000, "two_m21"});
        vectors.push_back('{32'h4100_0000, 32'h007F_FFFF, "pos_eight"});
        vectors.push_back('{32'hC100_0000, 32'hFF80_0000, "neg_eight"});
        vectors.push_back('{32'h40FF_FFFF, 32'h007F_FFFF, "just_below_8"});
        vectors.push_back('{32'hC0FF_FFFF, 32'hFF80_0001, "neg_just_below_8"});
        vectors.push_back('{32'h0000_0001, 32'h0000_0000, "denormal"});

        // Reset state, with and without enable
        apply_stimulus(1'b1, 1'b1, 32'h3F80_0000);
        check_output("reset_en1", 32'h0);
        apply_stimulus(1'b1, 1'b0, 32'h3F80_0000);
        check_output("reset_en0", 32'h0);

        // Directed table: hold each operand for 3 enabled edges
        foreach (vectors[i]) begin
            repeat (3) apply_stimulus(1'b0, 1'b1, vectors[i].dataa);
            check_output(vectors[i].name, vectors[i].expected);
        end

        // Back-to-back throughput
        apply_stimulus(1'b0, 1'b1, 32'h3F80_0000);
        apply_stimulus(1'b0, 1'b1, 32'hBFC0_0000);
        apply_stimulus(1'b0, 1'b1, 32'h4120_0000);
        check_output("b2b_0", 32'h0010_0000);
        apply_stimulus(1'b0, 1'b1, 32'h0000_0000);
        check_output("b2b_1", 32'hFFE8_0000);
        apply_stimulus(1'b0, 1'b1, 32'h0000_0000);
        check_output("b2b_2", 32'h007F_FFFF);

        // Stall: pipeline full of -1.5, then 1.0 with enable 1,0,0,1,1;
        // dataa carries other values while disabled and must be ignored
        repeat (3) apply_stimulus(1'b0, 1'b1, 32'hBFC0_0000);
        apply_stimulus(1'b0, 1'b1, 32'h3F80_0000);
        check_output("stall_e1", 32'hFFE8_0000);
        apply_stimulus(1'b0, 1'b0, 32'h4120_0000);
        check_output("stall_d1", 32'hFFE8_0000);
        apply_stimulus(1'b0, 1'b0, 32'hC2C8_0000);
        check_output("stall_d2", 32'hFFE8_0000);
        apply_stimulus(1'b0, 1'b1, 32'h3F80_0000);
        check_output("stall_e2", 32'hFFE8_0000);
        apply_stimulus(1'b0, 1'b1, 32'h3F80_0000);
        check_output("stall_e3", 32'h0010_0000);

        // Reset one edge after 1.0 is applied; the next operand is -1.5
        repeat (3) apply_stimulus(1'b0, 1'b1, 32'h4120_0000);
        apply_stimulus(1'b0, 1'b1, 32'h3F80_0000);
        apply_stimulus(1'b1, 1'b1, 32'h3F80_0000);
        check_output("rst_mid_0", 32'h0);
        apply_stimulus(1'b0, 1'b1, 32'hBFC0_0000);
        check_output("rst_mid_1", 32'h0);
        apply_stimulus(1'b0, 1'b1, 32'h3F80_0000);
        check_output("rst_mid_2", 32'h0);
        apply_stimulus(1'b0, 1'b1, 32'h3F80_0000);
        check_output("rst_mid_3", 32'hFFE8_0000);

        // Randomized operands, enable and occasional reset against the model
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom_range(0, 59) == 0),
                           ($urandom_range(0, 3) != 0),
                           random_operand());
            check_output("random", model_res);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/convert_8_bit.md
CONVERT_8_BIT -- requirements
Module: convert_8_bit

Interface
REQ-001 SHALL have parameter FLOAT_WIDTH, default 32, IEEE-754 single-precision input width.
REQ-002 SHALL have parameter INT_WIDTH, default 4, integer bits of the signed fixed-point format, sign bit included.
REQ-003 SHALL have parameter FRAC_WIDTH, default 20, fractional bits of the fixed-point format.
REQ-004 SHALL have parameter OUT_WIDTH, default 32, output bus width.
REQ-005 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port clk_en  input  1  pipeline advance enable.
REQ-008 SHALL have port dataa  input  FLOAT_WIDTH  IEEE-754 single-precision operand.
REQ-009 SHALL have port result  output  OUT_WIDTH  signed two's-complement fixed-point value, registered.

Function
REQ-010 SHALL convert dataa to signed Q(INT_WIDTH).(FRAC_WIDTH), i.e. Q4.20 in 24 bits, sign-extended to OUT_WIDTH bits.
REQ-011 SHALL be a 3-stage pipeline: S1 unpack (sign, exponent, 24-bit mantissa with hidden 1, class flags); S2 magnitude shift; S3 negate/saturate into result.
REQ-012 SHALL advance all stages only when clk_en=1; with clk_en=0 every pipeline register, result included, holds its value.
REQ-013 SHALL present a sample's conversion on result after exactly 3 rising edges with clk_en=1, with no internal valid flag; the consumer counts latency.
REQ-014 SHALL accept a new operand on every enabled cycle, giving a throughput of 1 per enabled cycle.
REQ-015 SHALL compute magnitude = mant24 shifted by (exp - 130): left shift when non-negative, right shift when negative; bits shifted out on a right shift are truncated.
REQ-016 SHALL round toward zero, truncating the magnitude before negation.
REQ-017 SHALL output the two's complement of the magnitude when the sign bit is 1.
REQ-018 SHALL output 0 when exp = 0 (zero or denormal), including -0.
REQ-019 SHALL output 0 when exp <= 106 (magnitude < 2^-20).
REQ-020 SHALL output 0 for NaN (exp = 255, mantissa != 0).
REQ-021 SHALL saturate when exp >= 130 (|value| >= 8.0), infinity included: positive -> 0x007FFFFF, negative -> 0xFF800000.
REQ-022 SHALL produce exactly 0xFF800000 for -8.0 and 0x007FFFFF for +8.0 (saturated).
REQ-023 SHALL leave the upper OUT_WIDTH-24 bits of result as copies of bit 23 in every case.
REQ-024 SHALL have no combinational path from dataa to result.

Reset
REQ-025 SHALL, when rst=1 at a rising edge, clear all pipeline stage registers and set result to 0, regardless of clk_en.
REQ-026 SHALL give rst priority over clk_en whenever both are 1 at the same edge.
REQ-027 SHALL discard samples in flight when reset occurs mid-conversion; result stays 0 until 3 enabled edges after the first post-reset operand.
REQ-028 SHALL NOT rely on initial blocks for functional reset values.

Verification
REQ-029 SHALL verify: dataa=0x3F800000 (1.0), clk_en=1 -> result=0x00100000 on the 3rd edge.
REQ-030 SHALL verify: dataa=0x3F1B74EE (0.607252935) -> 0x0009B74E; dataa=0xBFC00000 (-1.5) -> 0xFFE80000.
REQ-031 SHALL verify saturation and specials: 0x41200000 (10.0) -> 0x007FFFFF; 0xC2C80000 (-100.0) -> 0xFF800000; 0x7F800000 (+Inf) -> 0x007FFFFF; 0x7FC00000 (NaN) -> 0; 0x80000000 (-0) -> 0; 0x33800000 (2^-24) -> 0.
REQ-032 SHALL verify stall: 1.0 applied with clk_en toggling 1,0,0,1,1 -> result changes only on enabled edges and reaches 0x00100000 after the 3rd enabled edge.
REQ-033 SHALL verify back-to-back: operands 1.0, -1.5, 10.0 on consecutive enabled cycles -> results 0x00100000, 0xFFE80000, 0x007FFFFF on consecutive cycles starting at edge 3.
REQ-034 SHALL verify reset mid-operation: rst=1 one edge after 1.0 is applied -> result=0 and stays 0 until 3 enabled edges after the next operand.
